fp16_accum_driver: RTL and testbench
====================================

// Module: fp16_accum_driver
// PURPOSE
// - Initiator side of the floating_point_adder en/a/b -> ready/result interface.
// - Reduces a stream of FP16 values to one FP16 sum by issuing acc+x to an external adder, one element per add.
// - Sits between a TTPU operand stream (valid/ready) and the floating_point_adder instance at the parent level.
// PARAMETERS
// - DATA_WIDTH      16   operand/result width (FP16 only; other values unsupported)
// - CNT_WIDTH       8    element counter width; counts 1..2^CNT_WIDTH-1 per vector
// - TIMEOUT_CYCLES  64   max adder wait cycles (used only with FP_ACC_TIMEOUT_EN)
// PORTS
// - clk         in   1           clock; all logic on posedge
// - reset       in   1           synchronous, active-high reset
// - in_valid    in   1           input element valid
// - in_ready    out  1           driver can accept an element
// - in_data     in   DATA_WIDTH  FP16 element
// - in_last     in   1           element is last of vector
// - add_en      out  1           adder request; held with operands until add_ready
// - add_a       out  DATA_WIDTH  adder operand a (= accumulator)
// - add_b       out  DATA_WIDTH  adder operand b (= element)
// - add_ready   in   1           adder result valid (single-cycle pulse)
// - add_result  in   DATA_WIDTH  adder sum, valid with add_ready
// - out_valid   out  1           vector sum valid
// - out_ready   in   1           consumer accepts sum
// - out_data    out  DATA_WIDTH  FP16 vector sum
// - out_count   out  CNT_WIDTH   number of elements summed
// - err_timeout out  1           sticky adder timeout flag (0 when feature compiled out)
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE; acc=16'h0000, count=0; in_ready=0, add_en=0, add_a/add_b=0,
//   out_valid=0, out_data=0, out_count=0, err_timeout=0. Reset mid-operation aborts any add; add_en low next cycle.
// - FSM: IDLE -> ACCEPT (1 cycle after reset release) ; ACCEPT -> ISSUE on in_valid&&in_ready;
//   ISSUE -> WAIT_ADD ; WAIT_ADD -> ACCEPT on add_ready && !last ; WAIT_ADD -> OUTPUT on add_ready && last ;
//   OUTPUT -> ACCEPT on out_valid&&out_ready (acc/count cleared to 0 same edge).
// - ACCEPT: in_ready=1 only in ACCEPT; element, in_last captured on handshake; count+=1.
// - ISSUE/WAIT_ADD: add_en=1, add_a=acc, add_b=captured element; both stable until add_ready sampled high.
//   add_en drops the cycle after add_ready. add_ready outside WAIT_ADD is ignored.
// - add_ready: acc <= add_result. Latency in-handshake -> add_en high = 1 cycle.
// - OUTPUT: out_valid=1, out_data=acc, out_count=count; held stable until out_ready; no new input accepted.
// - Count saturates at 2^CNT_WIDTH-1; further elements still summed, out_count stays saturated.
// - No NaN/Inf/sign handling here; all FP16 arithmetic belongs to the adder. acc initial value +0 (16'h0000).
// - Simultaneous add_ready and reset: reset wins.
// CONFIGURATION
// - FP_ACC_TIMEOUT_EN defined: wait counter runs in WAIT_ADD; reaching TIMEOUT_CYCLES without add_ready sets
//   err_timeout (sticky until reset), drops add_en, returns to ACCEPT with acc/count cleared (vector discarded).
// - FP_ACC_TIMEOUT_EN undefined: no counter; WAIT_ADD waits indefinitely; err_timeout tied 0.
// STRUCTURE
// - ttpu_fp_pkg: FP16_WIDTH=16, FP16_ZERO=16'h0000, FP16_ONE=16'h3C00, fp_acc_state_t enum
//   {IDLE, ACCEPT, ISSUE, WAIT_ADD, OUTPUT}.
// - Single module, no sub-modules; floating_point_adder instanced by the parent, not inside this block.
// TESTING (bench instantiates this block plus floating_point_adder, or a ready-after-N-cycles adder model)
// - {3C00, 3C00(last)} -> out_data=4000 (2.0), out_count=2, out_valid held until out_ready.
// - {3C00, BC00(last)} -> out_data=0000 or 8000 (signed zero accepted), out_count=2.
// - Single element 4200(last) -> add_a=0000, add_b=4200; out_data=4200, out_count=1.
// - out_ready low 5 cycles in OUTPUT -> out_data/out_count stable, in_ready=0 throughout; next vector sums from 0.
// - Reset pulse during WAIT_ADD -> next cycle add_en=0, out_valid=0, acc=0; following vector {4000(last)} -> 4000.
// - FP_ACC_TIMEOUT_EN, model never asserts add_ready -> err_timeout=1 after 64 cycles, add_en=0, in_ready=1.

Source files
------------

// File: rtl/ttpu_fp_pkg.sv
// Shared FP16 constants and the accumulator-driver state encoding.
package ttpu_fp_pkg;

    localparam int FP16_WIDTH = 16;
    localparam logic [FP16_WIDTH-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP16_WIDTH-1:0] FP16_ONE  = 16'h3C00;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        ISSUE,
        WAIT_ADD,
        OUTPUT
    } fp_acc_state_t;

endpackage

// File: rtl/fp16_accum_driver.sv
// Reduces an FP16 element stream to one sum by issuing acc+x to an external adder.
// Optional adder watchdog: define FP_ACC_TIMEOUT_EN.
module fp16_accum_driver
    import ttpu_fp_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  add_en,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    input  logic                  add_ready,
    input  logic [DATA_WIDTH-1:0] add_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  err_timeout
);

    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [DATA_WIDTH-1:0] ACC_CLEAR = DATA_WIDTH'(FP16_ZERO);

    fp_acc_state_t         state_reg, state_next;
    logic [DATA_WIDTH-1:0] acc_reg, acc_next;
    logic [DATA_WIDTH-1:0] elem_reg, elem_next;
    logic                  last_reg, last_next;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;

`ifdef FP_ACC_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              err_reg, err_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            acc_reg   <= ACC_CLEAR;
            elem_reg  <= '0;
            last_reg  <= 1'b0;
            count_reg <= '0;
`ifdef FP_ACC_TIMEOUT_EN
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            elem_reg  <= elem_next;
            last_reg  <= last_next;
            count_reg <= count_next;
`ifdef FP_ACC_TIMEOUT_EN
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        elem_next  = elem_reg;
        last_next  = last_reg;
        count_next = count_reg;
`ifdef FP_ACC_TIMEOUT_EN
        wait_cnt_next = '0;
        err_next      = err_reg;
`endif
        case (state_reg)
            IDLE: state_next = ACCEPT;
            ACCEPT: begin
                if (in_valid) begin
                    elem_next  = in_data;
                    last_next  = in_last;
                    // Saturate so very long vectors still sum correctly, only the count clips.
                    count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT_ADD;
            WAIT_ADD: begin
                if (add_ready) begin
                    acc_next   = add_result;
                    state_next = last_reg ? OUTPUT : ACCEPT;
                end
`ifdef FP_ACC_TIMEOUT_EN
                else if (wait_cnt_reg == WAIT_LIMIT) begin
                    // Adder never answered: drop the partial vector and flag it.
                    err_next   = 1'b1;
                    acc_next   = ACC_CLEAR;
                    count_next = '0;
                    state_next = ACCEPT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
`endif
            end
            OUTPUT: begin
                if (out_ready) begin
                    acc_next   = ACC_CLEAR;
                    count_next = '0;
                    state_next = ACCEPT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == ACCEPT);
    assign add_en    = (state_reg == ISSUE) || (state_reg == WAIT_ADD);
    assign add_a     = add_en ? acc_reg : '0;
    assign add_b     = add_en ? elem_reg : '0;
    assign out_valid = (state_reg == OUTPUT);
    assign out_data  = out_valid ? acc_reg : '0;
    assign out_count = out_valid ? count_reg : '0;

`ifdef FP_ACC_TIMEOUT_EN
    assign err_timeout = err_reg;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fp16_accum_driver.sv
// Directed bench: the tasks play the operand source, a ready-after-N-cycles adder and the sum consumer.
module tb_fp16_accum_driver;

    localparam int DW = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          add_en;
    logic [DW-1:0] add_a;
    logic [DW-1:0] add_b;
    logic          add_ready;
    logic [DW-1:0] add_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    fp16_accum_driver #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .add_en(add_en), .add_a(add_a), .add_b(add_b),
        .add_ready(add_ready), .add_result(add_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Offers one element from a negedge and returns on the negedge after the handshake.
    task automatic send(input logic [DW-1:0] data, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_in_ready: in_ready=%b required 1 (data %h)", in_ready, data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Adder model: checks the request issued one cycle after the handshake, answers after dly cycles.
    task automatic do_add(input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                          input logic [DW-1:0] sum, input int dly);
        n_checks++;
        if ({add_en, add_a, add_b, in_ready} !== {1'b1, ea, eb, 1'b0}) begin
            n_fail++;
            $display("FAIL add_issue: en=%b a=%h b=%h in_ready=%b required en=1 a=%h b=%h in_ready=0",
                     add_en, add_a, add_b, in_ready, ea, eb);
        end
        repeat (dly) @(negedge clk);
        n_checks++;
        if ({add_en, add_a, add_b} !== {1'b1, ea, eb}) begin
            n_fail++;
            $display("FAIL add_hold: en=%b a=%h b=%h required en=1 a=%h b=%h",
                     add_en, add_a, add_b, ea, eb);
        end
        add_ready  = 1'b1;
        add_result = sum;
        @(negedge clk);
        add_ready  = 1'b0;
        add_result = 16'h0000;
        n_checks++;
        if (add_en !== 1'b0) begin
            n_fail++;
            $display("FAIL add_drop: add_en=%b required 0", add_en);
        end
    endtask

    // Consumer: holds out_ready low for hold cycles, then accepts the sum.
    task automatic recv(input logic [DW-1:0] edata, input logic [CW-1:0] ecount,
                        input int hold, input logic zero_ok);
        logic data_ok;
        for (int i = 0; i <= hold; i++) begin
            data_ok = (out_data === edata) || (zero_ok && out_data === 16'h8000);
            n_checks++;
            if (!(out_valid === 1'b1 && data_ok && out_count === ecount && in_ready === 1'b0)) begin
                n_fail++;
                $display("FAIL out_hold[%0d]: valid=%b data=%h count=%0d in_ready=%b required valid=1 data=%h count=%0d in_ready=0",
                         i, out_valid, out_data, out_count, in_ready, edata, ecount);
            end
            if (i < hold) @(negedge clk);
        end
        $display("vector sum=%h count=%0d (expected %h/%0d)", out_data, out_count, edata, ecount);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL out_release: valid=%b in_ready=%b data=%h required 0/1/0000",
                     out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, add_en, add_a, add_b, out_valid, out_data, out_count, err_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b add_en=%b a=%h b=%h out_valid=%b data=%h count=%0d err=%b required all 0",
                     in_ready, add_en, add_a, add_b, out_valid, out_data, out_count, err_timeout);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_to_accept: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_two_ones;
        send(16'h3C00, 1'b0);
        do_add(16'h0000, 16'h3C00, 16'h3C00, 1);
        send(16'h3C00, 1'b1);
        do_add(16'h3C00, 16'h3C00, 16'h4000, 3);
        recv(16'h4000, 3'd2, 5, 1'b0);
    endtask

    task automatic test_cancel;
        send(16'h3C00, 1'b0);
        do_add(16'h0000, 16'h3C00, 16'h3C00, 2);
        send(16'hBC00, 1'b1);
        do_add(16'h3C00, 16'hBC00, 16'h0000, 1);
        recv(16'h0000, 3'd2, 0, 1'b1);
    endtask

    task automatic test_single;
        send(16'h4200, 1'b1);
        do_add(16'h0000, 16'h4200, 16'h4200, 4);
        recv(16'h4200, 3'd1, 1, 1'b0);
    endtask

    task automatic test_saturation;
        logic [DW-1:0] sums [9] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                                    16'h4600, 16'h4700, 16'h4800, 16'h4880};
        for (int i = 0; i < 9; i++) begin
            send(16'h3C00, i == 8);
            do_add((i == 0) ? 16'h0000 : sums[i-1], 16'h3C00, sums[i], 1);
        end
        recv(16'h4880, 3'd7, 2, 1'b0);
    endtask

    task automatic test_reset_mid_add;
        send(16'h3C00, 1'b0);
        @(negedge clk);
        // Adder answers in the same cycle as the reset: reset must win.
        reset      = 1'b1;
        add_ready  = 1'b1;
        add_result = 16'h5555;
        @(negedge clk);
        add_ready  = 1'b0;
        add_result = 16'h0000;
        n_checks++;
        if ({add_en, out_valid, in_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_add: add_en=%b out_valid=%b in_ready=%b required 0/0/0",
                     add_en, out_valid, in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        send(16'h4000, 1'b1);
        do_add(16'h0000, 16'h4000, 16'h4000, 2);
        recv(16'h4000, 3'd1, 0, 1'b0);
    endtask

    task automatic test_no_timeout_flag;
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL err_timeout_idle: err_timeout=%b required 0", err_timeout);
        end
    endtask

`ifdef FP_ACC_TIMEOUT_EN
    task automatic test_timeout;
        int cyc = 0;
        send(16'h3C00, 1'b1);
        while (!err_timeout && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        $display("timeout flagged after %0d cycles", cyc);
        n_checks++;
        if ({err_timeout, add_en, in_ready} !== 3'b101 || cyc < 60 || cyc > 70) begin
            n_fail++;
            $display("FAIL timeout: err=%b add_en=%b in_ready=%b cycles=%0d required 1/0/1 near 64",
                     err_timeout, add_en, in_ready, cyc);
        end
        send(16'h4000, 1'b1);
        do_add(16'h0000, 16'h4000, 16'h4000, 1);
        recv(16'h4000, 3'd1, 0, 1'b0);
    endtask
`endif

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        add_ready  = 1'b0;
        add_result = '0;
        out_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_two_ones();
        test_single();
        test_cancel();
        test_saturation();
        test_reset_mid_add();
        test_no_timeout_flag();
`ifdef FP_ACC_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
